// File: rtl/lshift_deser_ctrl.sv
// lshift_deser_ctrl: sequences a left shift register as a framed serial-to-parallel deserializer
module lshift_deser_ctrl #(
    parameter int reg_size = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sin_valid,
    input  logic                              sin_data,
    input  logic                              sin_sof,
    output logic                              sin_ready,
    output logic                              shl,
    output logic                              d,
    input  logic [reg_size-1:0]               q_in,
    output logic                              word_valid,
    output logic [reg_size-1:0]               word_data,
    input  logic                              word_ready,
    output logic [$clog2(reg_size+1)-1:0]     bit_cnt,
    output logic                              err_sync,
    output logic                              err_timeout
);
    localparam int CW = $clog2(reg_size + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    localparam logic [CW-1:0] LAST_CNT = CW'(reg_size - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [IW-1:0] idle_cnt;
    logic          accept;

    assign sin_ready  = state != FULL;
    assign accept     = sin_valid & sin_ready;
    assign d          = sin_data;
    assign shl        = accept & (state == SHIFT | sin_sof);
    assign word_valid = state == FULL;
    assign word_data  = word_valid ? q_in : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
            err_sync    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_sync    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: if (accept && sin_sof) begin
                    state   <= SHIFT;
                    bit_cnt <= CW'(1);
                end
                SHIFT: if (accept) begin
                    idle_cnt <= '0;
                    if (sin_sof) begin
                        bit_cnt  <= CW'(1);
                        err_sync <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == LAST_CNT) state <= FULL;
                    end
                end else if (idle_cnt == IDLE_MAX) begin
                    // stalled frame is abandoned; partial word is lost
                    state       <= IDLE;
                    bit_cnt     <= '0;
                    idle_cnt    <= '0;
                    err_timeout <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
                FULL: if (word_ready) begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lshift_deser_ctrl.sv
// tb_lshift_deser_ctrl: directed plus randomized checks against a queue-based frame model
module tb_lshift_deser_ctrl;
    localparam int RS = 4;
    localparam int TO = 16;

    logic clk = 0, rst = 1, sin_valid = 0, sin_data = 0, sin_sof = 0, word_ready = 0;
    logic sin_ready, shl, d, word_valid, err_sync, err_timeout;
    logic [RS-1:0] q, word_data;
    logic [$clog2(RS+1)-1:0] bit_cnt;
    int checks = 0, errors = 0, n_sync = 0, n_tmo = 0;

    lshift_deser_ctrl #(.reg_size(RS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_data(sin_data), .sin_sof(sin_sof),
        .sin_ready(sin_ready), .shl(shl), .d(d), .q_in(q), .word_valid(word_valid),
        .word_data(word_data), .word_ready(word_ready), .bit_cnt(bit_cnt),
        .err_sync(err_sync), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // the controlled shift register
    always @(posedge clk) if (shl) q <= {q[RS-2:0], d};

    // reference: frame = queue of accepted bits; its length is the whole story
    bit mq[$];
    int m_idle = 0;
    bit m_es = 0, m_et = 0, started = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete(); m_idle = 0; m_es = 0; m_et = 0; started = 1;
        end else begin
            m_es = 0; m_et = 0;
            if (mq.size() == RS) begin
                if (word_ready) mq.delete();
            end else if (sin_valid) begin
                m_idle = 0;
                if (sin_sof) begin
                    m_es = mq.size() > 0;
                    mq.delete();
                    mq.push_back(sin_data);
                end else if (mq.size() > 0) mq.push_back(sin_data);
            end else if (mq.size() > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    mq.delete(); m_idle = 0; m_et = 1;
                end
            end
        end
    end

    function automatic logic [RS-1:0] mword();
        logic [RS-1:0] w = '0;
        foreach (mq[i]) w = {w[RS-2:0], mq[i]};
        return w;
    endfunction

    always @(negedge clk) begin
        logic [12:0] a, e;
        logic er, es;
        if (started) begin
            er = mq.size() < RS;
            es = sin_valid && er && (mq.size() > 0 || sin_sof);
            e = {er, es, sin_data, mq.size() == RS, (mq.size() == RS) ? mword() : 4'b0,
                 3'(mq.size()), m_es, m_et};
            a = {sin_ready, shl, d, word_valid, word_data, bit_cnt, err_sync, err_timeout};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t act=%b exp=%b (rdy,shl,d,wv,wd,cnt,es,et)", $time, a, e);
            end
            n_sync += int'(err_sync);
            n_tmo += int'(err_timeout);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input bit dt, input bit sf, input bit eshl, input int ecnt);
        sin_valid = 1; sin_data = dt; sin_sof = sf;
        #1 chk("shl", shl, eshl);
        @(posedge clk); #1;
        chk("bit_cnt", bit_cnt, ecnt);
    endtask

    task automatic idle(input int n);
        sin_valid = 0; sin_sof = 0;
        repeat (n) step();
    endtask

    task automatic word_chk(input string nm, input int w);
        sin_valid = 0; sin_sof = 0;
        #1 chk({nm, "_wv"}, word_valid, 1);
        chk({nm, "_wd"}, word_data, w);
        chk({nm, "_rdy"}, sin_ready, 0);
    endtask

    task automatic release_word();
        sin_valid = 0; word_ready = 1;
        step();
        word_ready = 0;
    endtask

    int ns0, nt0, pv;

    initial begin
        step(); step();
        rst = 0;
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_wv", word_valid, 0);
        // frame 1011
        send(1, 1, 1, 1); send(0, 0, 1, 2); send(1, 0, 1, 3); send(1, 0, 1, 4);
        word_chk("t1", 4'b1011);
        release_word();
        #1 chk("t1_rdy", sin_ready, 1);
        chk("t1_cnt", bit_cnt, 0);
        // held word under back-pressure
        nt0 = n_tmo;
        send(0, 1, 1, 1); send(1, 0, 1, 2); send(1, 0, 1, 3); send(0, 0, 1, 4);
        for (int i = 0; i < 10; i++) begin
            sin_valid = 1; sin_data = 1; sin_sof = 0;
            #1 chk("t2_shl", shl, 0);
            chk("t2_wd", word_data, 4'b0110);
            step();
        end
        chk("t2_tmo", n_tmo - nt0, 0);
        release_word();
        // resync
        ns0 = n_sync;
        send(1, 1, 1, 1); send(1, 0, 1, 2); send(0, 1, 1, 1); send(0, 0, 1, 2); send(1, 0, 1, 3); send(1, 0, 1, 4);
        word_chk("t3", 4'b0011);
        chk("t3_sync", n_sync - ns0, 1);
        release_word();
        // timeout
        nt0 = n_tmo;
        send(1, 1, 1, 1); send(0, 0, 1, 2);
        idle(TO);
        chk("t4_et", err_timeout, 1);
        chk("t4_cnt", bit_cnt, 0);
        chk("t4_rdy", sin_ready, 1);
        step();
        chk("t4_tmo", n_tmo - nt0, 1);
        send(1, 1, 1, 1); send(1, 0, 1, 2); send(0, 0, 1, 3); send(1, 0, 1, 4);
        word_chk("t4", 4'b1101);
        release_word();
        // stray bits in IDLE
        send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 0, 0, 0);
        send(0, 1, 1, 1); send(0, 0, 1, 2); send(0, 0, 1, 3); send(1, 0, 1, 4);
        word_chk("t5", 4'b0001);
        release_word();
        // reset mid-frame and in FULL, then long but legal gaps
        ns0 = n_sync; nt0 = n_tmo;
        send(1, 1, 1, 1); send(0, 0, 1, 2); send(1, 0, 1, 3);
        sin_valid = 1; rst = 1; step(); rst = 0; sin_valid = 0;
        #1 chk("t6_cnt", bit_cnt, 0);
        chk("t6_wv", word_valid, 0);
        send(1, 1, 1, 1); send(1, 0, 1, 2); send(1, 0, 1, 3); send(1, 0, 1, 4);
        sin_valid = 0; rst = 1; step(); rst = 0;
        #1 chk("t6_full_wv", word_valid, 0);
        chk("t6_full_cnt", bit_cnt, 0);
        chk("t6_full_rdy", sin_ready, 1);
        send(1, 1, 1, 1); idle(TO - 1);
        send(0, 0, 1, 2); idle(TO - 1);
        send(1, 0, 1, 3); idle(TO - 1);
        send(0, 0, 1, 4);
        word_chk("t6", 4'b1010);
        chk("t6_errs", (n_sync - ns0) + (n_tmo - nt0), 0);
        release_word();
        // randomized traffic in phases of varying density
        for (int p = 0; p < 60; p++) begin
            pv = (p % 3 == 0) ? 10 : (p % 3 == 1) ? 60 : 100;
            for (int c = 0; c < 50; c++) begin
                sin_valid = $urandom_range(99) < pv;
                sin_data = $urandom_range(1);
                sin_sof = $urandom_range(99) < 12;
                word_ready = $urandom_range(99) < 50;
                rst = $urandom_range(299) == 0;
                step();
            end
        end
        rst = 0; sin_valid = 0; word_ready = 0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
